xor_keystream_gen: RTL
======================

// Module: xor_keystream_gen
// PURPOSE
//   Keystream source placed directly upstream of the XOR encryption stage.
//   Collects a KEY_BYTES-byte key serially and seeds a Galois LFSR with it.
//   Runs WARMUP byte-steps of warm-up, then supplies one keystream byte per
//   valid/ready handshake. The XOR stage combines each byte with the data byte.
// PARAMETERS
//   KEY_BYTES  4             key length in bytes; LFSR width W = 8*KEY_BYTES
//   TAPS       32'h80200003  Galois feedback mask, W bits
//   WARMUP     16            byte-steps discarded after key load; must be >= 1
// PORTS
//   clk        in   1  clock; all logic on the rising edge
//   rst        in   1  synchronous, active-high reset
//   key_valid  in   1  key_byte is valid
//   key_byte   in   8  key byte; MSB byte first
//   key_ready  out  1  key byte accepted when key_valid && key_ready
//   rekey      in   1  one-cycle pulse: discard state and reload the key
//   ks_valid   out  1  ks_byte is valid
//   ks_byte    out  8  keystream byte = lfsr[7:0]
//   ks_ready   in   1  XOR stage consumes ks_byte when ks_valid && ks_ready
//   busy       out  1  high during warm-up
// BEHAVIOUR
//   Reset: state LOAD, lfsr = 0, byte count = 0, warm-up count = 0.
//     Outputs after reset: key_ready=1, ks_valid=0, ks_byte=0x00, busy=0.
//   bit-step: s = s[0] ? (s>>1)^TAPS : (s>>1).
//   byte-step: 8 bit-steps, unrolled and completed in a single cycle.
//   FSM states:
//     LOAD: key_ready=1.
//       On each accept: lfsr = {lfsr[W-9:0], key_byte}, count++.
//       On accept number KEY_BYTES: if the assembled W-bit value is 0,
//         load 1 instead (avoids LFSR lock-up); then go to WARM.
//     WARM: busy=1, key_ready=0; one byte-step per cycle.
//       After WARMUP cycles go to RUN.
//     RUN: ks_valid=1. On a handshake, lfsr does one byte-step; the next
//       byte appears the following cycle. No bubble between bytes.
//   Timing: last key byte accepted at edge N -> ks_valid=1 after edge
//     N+WARMUP. The first ks_byte reflects exactly WARMUP byte-steps.
//   Stall: ks_valid && !ks_ready holds ks_byte and lfsr unchanged.
//   key_valid outside LOAD: ignored (key_ready=0).
//   rekey, any state: next state LOAD, count=0, lfsr=0, ks_valid=0, busy=0.
//     rekey with a RUN handshake in the same cycle: that byte counts as
//     consumed and rekey still applies.
//     rekey with a LOAD key accept in the same cycle: rekey wins and the
//     byte is dropped.
//   rst mid-operation, any state: same effect as reset; no partial outputs.
//   Counters: byte count is $clog2(KEY_BYTES+1) bits; warm-up count is
//     $clog2(WARMUP+1) bits; neither wraps.
// TESTING
//   1. rst for 2 cycles -> key_ready=1, ks_valid=0, ks_byte=0x00, busy=0.
//   2. WARMUP=1, key bytes 00,00,00,01 -> busy=1 for 1 cycle, then
//      ks_valid=1, ks_byte=0x02 (lfsr=0xDB36C002).
//   3. WARMUP=1, key 00,00,00,00 -> zero-key substitution gives the same
//      result as scenario 2: ks_byte=0x02.
//   4. From scenario 2, hold ks_ready=0 for 5 cycles -> ks_byte stays 0x02
//      and lfsr stays 0xDB36C002. Then ks_ready=1 for 1 cycle -> next
//      ks_byte = low byte of one byte-step of 0xDB36C002, checked against
//      the bench model.
//   5. In RUN, pulse rekey while ks_ready=1 -> ks_valid=0 next cycle,
//      key_ready=1. Reload key 00,00,00,01 -> first ks_byte=0x02 again.
//   6. Random key, WARMUP=16, random ks_ready, 1000 bytes -> stream matches
//      the bench Galois model byte for byte; rst asserted mid-stream returns
//      all outputs to reset values.

Source files
------------

// File: rtl/xks_if.sv
// Handshake bundle between the key/keystream consumer and xor_keystream_gen.
// The slave side is the keystream generator itself.
interface xks_if;
  logic       key_valid;
  logic [7:0] key_byte;
  logic       key_ready;
  logic       rekey;
  logic       ks_valid;
  logic [7:0] ks_byte;
  logic       ks_ready;
  logic       busy;

  modport master (
    output key_valid, key_byte, rekey, ks_ready,
    input  key_ready, ks_valid, ks_byte, busy
  );

  modport slave (
    input  key_valid, key_byte, rekey, ks_ready,
    output key_ready, ks_valid, ks_byte, busy
  );
endinterface

// File: rtl/xor_keystream_gen.sv
// Galois-LFSR keystream source: serial key load, fixed warm-up, then one
// keystream byte per valid/ready handshake.
module xor_keystream_gen #(
  parameter int                     KEY_BYTES = 4,
  parameter logic [8*KEY_BYTES-1:0] TAPS      = 32'h80200003,
  parameter int                     WARMUP    = 16
) (
  input  logic  clk,
  input  logic  rst,
  xks_if.slave  ks
);
  localparam int W   = 8 * KEY_BYTES;
  localparam int BCW = $clog2(KEY_BYTES + 1);
  localparam int WCW = $clog2(WARMUP + 1);
  localparam logic [BCW-1:0] BLAST = BCW'(KEY_BYTES - 1);
  localparam logic [WCW-1:0] WLAST = WCW'(WARMUP - 1);

  typedef enum logic [1:0] {LOAD, WARM, RUN} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   lfsr_q, lfsr_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [W-1:0]   key_word;
  logic [W-1:0]   lfsr_step;

  // Eight Galois bit-steps, fully unrolled into one cycle.
  function automatic logic [W-1:0] byte_step(input logic [W-1:0] s);
    logic [W-1:0] t;
    t = s;
    for (int i = 0; i < 8; i++)
      t = t[0] ? ((t >> 1) ^ TAPS) : (t >> 1);
    return t;
  endfunction

  assign key_word  = (lfsr_q << 8) | W'(ks.key_byte);
  assign lfsr_step = byte_step(lfsr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      lfsr_q  <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    // rekey overrides everything, including a same-cycle key accept.
    if (ks.rekey) begin
      state_d = LOAD;
      lfsr_d  = '0;
      bcnt_d  = '0;
      wcnt_d  = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (ks.key_valid) begin
            if (bcnt_q == BLAST) begin
              // An all-zero seed would lock the LFSR at zero forever.
              lfsr_d  = (key_word == '0) ? W'(1) : key_word;
              bcnt_d  = '0;
              wcnt_d  = '0;
              state_d = WARM;
            end else begin
              lfsr_d = key_word;
              bcnt_d = bcnt_q + BCW'(1);
            end
          end
        end
        WARM: begin
          lfsr_d = lfsr_step;
          if (wcnt_q == WLAST) begin
            wcnt_d  = '0;
            state_d = RUN;
          end else begin
            wcnt_d = wcnt_q + WCW'(1);
          end
        end
        RUN: begin
          if (ks.ks_ready) lfsr_d = lfsr_step;
        end
        default: state_d = LOAD;
      endcase
    end
  end

  assign ks.key_ready = (state_q == LOAD);
  assign ks.busy      = (state_q == WARM);
  assign ks.ks_valid  = (state_q == RUN);
  // Gate the byte so partial key material never leaks outside RUN.
  assign ks.ks_byte   = (state_q == RUN) ? lfsr_q[7:0] : 8'h00;
endmodule
